// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store controller: FSM states,
// RV32 load/store size encodings and request legality checks.
package lsu_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        MERGE,
        WRITE,
        RESP
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
        case (funct3)
            F3_H, F3_HU: return offset[0];
            F3_W:        return (offset != 2'b00);
            default:     return 1'b0;
        endcase
    endfunction

    // Unsigned sizes exist only for loads.
    function automatic logic is_illegal(input logic [2:0] funct3, input logic we);
        case (funct3)
            F3_B, F3_H, F3_W: return 1'b0;
            F3_BU, F3_HU:     return we;
            default:          return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering between a memory word and a sub-word access:
// load extraction with sign/zero extension, and store merge into the old word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    input  logic [1:0]        offset,
    input  logic [2:0]        funct3,
    input  logic [WORD_W-1:0] store_data,
    output logic [WORD_W-1:0] load_data,
    output logic [WORD_W-1:0] merged
);

    logic [4:0]        shamt;
    logic [WORD_W-1:0] shifted;
    logic [WORD_W-1:0] mask;

    assign shamt   = {offset, 3'b000};
    assign shifted = word >> shamt;

    always_comb begin
        load_data = word;
        case (funct3)
            F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   load_data = {24'h000000, shifted[7:0]};
            F3_HU:   load_data = {16'h0000, shifted[15:0]};
            default: load_data = word;
        endcase
    end

    // Lanes outside the mask keep the value just read from memory.
    always_comb begin
        mask = '1;
        case (funct3)
            F3_B, F3_BU: mask = 32'h0000_00FF << shamt;
            F3_H, F3_HU: mask = 32'h0000_FFFF << shamt;
            default:     mask = '1;
        endcase
        merged = (word & ~mask) | ((store_data << shamt) & mask);
    end

endmodule

// File: rtl/lsu_controller.sv
// Load/store sequencer for a word-only single-port data memory: one request
// in flight, read-modify-write for sub-word stores, one response per request.
module lsu_controller
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int MEM_AW        = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [2:0]               req_funct3,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [DATA_WIDTH-1:0]    resp_data,
    output logic                     resp_err,
    output logic [MEM_AW-1:0]        mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wd,
    output logic                     mem_we,
    input  logic [DATA_WIDTH-1:0]    mem_rd
);

    lsu_state_e state_q, state_d;

    logic                  we_q;
    logic [2:0]            f3_q;
    logic [1:0]            off_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] resp_data_q;
    logic                  resp_err_q;
    logic [MEM_AW-1:0]     mem_addr_q;

    logic                  accept;
    logic                  req_err;
    logic                  write_c;
    logic [DATA_WIDTH-1:0] wd_c;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] merged;
    logic                  addr_hi_unused;

    assign addr_hi_unused = ^req_addr[ADDRESS_WIDTH-1:MEM_AW+2];

    assign req_ready = (state_q == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign req_err   = is_illegal(req_funct3, req_we) || is_misaligned(req_funct3, req_addr[1:0]);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        write_c = 1'b0;
        wd_c    = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_err)                          state_d = RESP;
                    else if (req_we && req_funct3 == F3_W) state_d = WRITE;
                    else                                   state_d = READ;
                end
            end
            READ:  state_d = MERGE;
            MERGE: begin
                state_d = RESP;
                if (we_q) begin
                    write_c = 1'b1;
                    wd_c    = merged;
                end
            end
            WRITE: begin
                state_d = RESP;
                write_c = 1'b1;
                wd_c    = wdata_q;
            end
            RESP:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request fields only matter between accept and response, so they skip reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            off_q   <= req_addr[1:0];
            wdata_q <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
            mem_addr_q  <= '0;
        end else if (accept) begin
            resp_data_q <= '0;
            resp_err_q  <= req_err;
            mem_addr_q  <= req_addr[MEM_AW+1:2];
        end else if (state_q == MERGE && !we_q) begin
            resp_data_q <= load_data;
        end
    end

    lsu_lane_align u_align (
        .word       (mem_rd),
        .offset     (off_q),
        .funct3     (f3_q),
        .store_data (wdata_q),
        .load_data  (load_data),
        .merged     (merged)
    );

    // The state register still holds the pre-reset state during a reset cycle.
    assign mem_we     = write_c && !rst;
    assign mem_wd     = rst ? '0 : wd_c;
    assign mem_addr   = mem_addr_q;
    assign resp_valid = (state_q == RESP) && !rst;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_lsu_controller.sv
// Directed bench for lsu_controller with a registered-read word memory model
// and a queue of expected responses.
module tb_lsu_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;
    logic [15:0] mem_addr;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    logic [31:0] mem [0:65535];

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic [15:0] waddr;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    lsu_controller dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wd     (mem_wd),
        .mem_we     (mem_we),
        .mem_rd     (mem_rd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wd;
        mem_rd <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        @(negedge clk);
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    endtask

    task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
    endtask

    // exp_wcyc = 0 means no memory write is allowed.
    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int exp_lat, input int exp_wcyc, input logic [31:0] exp_wd,
                          input logic [31:0] exp_data, input logic exp_err, input int hold);
        int          k, lat, wcyc, nwr;
        logic        got;
        logic [31:0] wd;
        logic [15:0] wa;
        exp_t        e;
        wait_ready();
        resp_ready = (hold == 0);
        sb.push_back('{data: exp_data, err: exp_err, waddr: addr[17:2]});
        drive(we, f3, addr, wdata);
        k = 0; lat = 0; wcyc = 0; nwr = 0; got = 1'b0; wd = '0; wa = '0;
        while (!got && k < 10) begin
            k++;
            @(negedge clk);
            if (mem_we) begin
                wcyc = k;
                nwr++;
                wd = mem_wd;
                wa = mem_addr;
            end
            if (resp_valid) begin
                got = 1'b1;
                lat = k;
            end
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        e = sb.pop_front();
        chk({tag, "_resp_data"}, resp_data, e.data);
        chk({tag, "_resp_err"}, {31'b0, resp_err}, {31'b0, e.err});
        chk({tag, "_req_ready_in_resp"}, {31'b0, req_ready}, 32'd0);
        chk({tag, "_nwrites"}, 32'(nwr), (exp_wcyc != 0) ? 32'd1 : 32'd0);
        if (exp_wcyc != 0) begin
            chk({tag, "_write_cycle"}, 32'(wcyc), 32'(exp_wcyc));
            chk({tag, "_mem_wd"}, wd, exp_wd);
            chk({tag, "_mem_addr"}, {16'b0, wa}, {16'b0, e.waddr});
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, {31'b0, resp_valid}, 32'd1);
            chk({tag, "_hold_data"}, resp_data, e.data);
            chk({tag, "_hold_addr"}, {16'b0, mem_addr}, {16'b0, e.waddr});
            chk({tag, "_hold_ready"}, {31'b0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_resp_done"}, {31'b0, resp_valid}, 32'd0);
        chk({tag, "_ready_after"}, {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_mem_addr", {16'b0, mem_addr}, 32'd0);
        chk("rst_mem_wd", mem_wd, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_release_ready", {31'b0, req_ready}, 32'd1);

        // Word store and word load
        do_req("sw", 1, 3'b010, 32'h10, 32'hDEADBEEF, 2, 1, 32'hDEADBEEF, 32'h0, 0, 0);
        do_req("lw", 0, 3'b010, 32'h10, 32'h0, 3, 0, 32'h0, 32'hDEADBEEF, 0, 0);

        // Byte store and byte loads
        do_req("sw_init1", 1, 3'b010, 32'h10, 32'h11223344, 2, 1, 32'h11223344, 32'h0, 0, 0);
        do_req("sb", 1, 3'b000, 32'h13, 32'h000000AA, 3, 2, 32'hAA223344, 32'h0, 0, 0);
        do_req("lb", 0, 3'b000, 32'h13, 32'h0, 3, 0, 32'h0, 32'hFFFFFFAA, 0, 0);
        do_req("lbu", 0, 3'b100, 32'h13, 32'h0, 3, 0, 32'h0, 32'h000000AA, 0, 0);

        // Halfword store and halfword loads
        do_req("sw_init2", 1, 3'b010, 32'h10, 32'h11223344, 2, 1, 32'h11223344, 32'h0, 0, 0);
        do_req("sh", 1, 3'b001, 32'h12, 32'h00008001, 3, 2, 32'h80013344, 32'h0, 0, 0);
        do_req("lh", 0, 3'b001, 32'h12, 32'h0, 3, 0, 32'h0, 32'hFFFF8001, 0, 0);
        do_req("lhu", 0, 3'b101, 32'h12, 32'h0, 3, 0, 32'h0, 32'h00008001, 0, 0);
        do_req("lh_lo", 0, 3'b001, 32'h10, 32'h0, 3, 0, 32'h0, 32'h00003344, 0, 0);
        do_req("lb_1", 0, 3'b000, 32'h11, 32'h0, 3, 0, 32'h0, 32'h00000033, 0, 0);
        do_req("sb_hi_garbage", 1, 3'b000, 32'h10, 32'h123456F0, 3, 2, 32'h800133F0, 32'h0, 0, 0);

        // Error cases: no memory write, data forced to zero
        do_req("err_lw_mis", 0, 3'b010, 32'h06, 32'h0, 1, 0, 32'h0, 32'h0, 1, 0);
        do_req("err_sh_mis", 1, 3'b001, 32'h11, 32'h5555, 1, 0, 32'h0, 32'h0, 1, 0);
        do_req("err_f3_011", 0, 3'b011, 32'h10, 32'h0, 1, 0, 32'h0, 32'h0, 1, 0);
        do_req("err_sbu", 1, 3'b100, 32'h10, 32'h77, 1, 0, 32'h0, 32'h0, 1, 0);
        do_req("lw_after_err", 0, 3'b010, 32'h10, 32'h0, 3, 0, 32'h0, 32'h800133F0, 0, 0);

        // Consumer stalls the response
        do_req("lw_hold", 0, 3'b010, 32'h10, 32'h0, 3, 0, 32'h0, 32'h800133F0, 0, 5);

        // Reset landing on the MERGE cycle of a byte store
        wait_ready();
        drive(1, 3'b000, 32'h10, 32'h00000055);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_merge_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_merge_mem_wd", mem_wd, 32'd0);
        chk("rst_merge_resp_valid", {31'b0, resp_valid}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_merge_ready_after", {31'b0, req_ready}, 32'd1);
        chk("rst_merge_mem_unchanged", mem[16'd4], 32'h800133F0);
        repeat (4) @(negedge clk);
        chk("rst_merge_no_resp", {31'b0, resp_valid}, 32'd0);

        // Reset landing on the WRITE cycle of a word store
        wait_ready();
        drive(1, 3'b010, 32'h10, 32'hCAFEF00D);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_write_mem_we", {31'b0, mem_we}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_write_ready_after", {31'b0, req_ready}, 32'd1);
        chk("rst_write_no_resp", {31'b0, resp_valid}, 32'd0);
        do_req("lw_after_rst", 0, 3'b010, 32'h10, 32'h0, 3, 0, 32'h0, 32'h800133F0, 0, 0);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_controller.md
# lsu_controller

Load/store controller that sequences the word-only, single-port synchronous data memory on behalf of the core's memory stage. It accepts one byte/halfword/word load or store per transaction over a valid/ready handshake and converts byte addresses to word addresses. It performs read-modify-write for sub-word stores and extracts, then sign- or zero-extends, sub-word load data. It returns exactly one response per accepted request.

## Interface
- DATA_WIDTH, 32, data and memory word width (fixed at 32; byte lanes assume 4 bytes)
- ADDRESS_WIDTH, 32, byte-address width of requests
- MEM_AW, 16, word-address width driven to the memory
---
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32 size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  ADDRESS_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data, right-aligned
- resp_valid  out  1  response present; held until accepted
- resp_ready  in  1  consumer accepts response
- resp_data  out  DATA_WIDTH  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned or illegal funct3; no memory write occurred
- mem_addr  out  MEM_AW  word address = req_addr[MEM_AW+1:2]
- mem_wd  out  DATA_WIDTH  write data
- mem_we  out  1  write enable
- mem_rd  in  DATA_WIDTH  registered read data; valid the cycle after mem_addr is presented

## Operation
- States:
  - IDLE: req_ready=1. On req_valid, latch the request.
    - Illegal funct3 (011, 110, 111; or 100/101 with req_we=1) -> RESP with err.
    - Misaligned access (H with addr[0]≠0, W with addr[1:0]≠0) -> RESP with err.
    - Word store -> WRITE.
    - Sub-word store or any load -> READ.
  - READ: drive latched word address, mem_we=0 -> MERGE.
  - MERGE: mem_rd valid.
    - Load: select the lane by addr[1:0] and extend (B/H sign-extend; BU/HU zero-extend), register into resp_data.
    - Sub-word store: mem_wd = mem_rd with the addressed byte/half replaced by req_wdata[7:0]/[15:0], mem_we=1.
    - -> RESP.
  - WRITE: mem_wd=req_wdata, mem_we=1 -> RESP.
  - RESP: resp_valid=1. When resp_ready -> IDLE. A new request is not accepted in the same cycle.
- resp_data, resp_err and mem_addr are stable while in RESP.
- mem_we is high only in WRITE or MERGE-with-store, and is gated by !rst.
- Byte lanes are little-endian: lane n = bits [8n+7:8n].

## Timing
- Accept cycle = c0. resp_valid first asserted:
  - Load: c3.
  - Sub-word store: c3, with the write in c2.
  - Word store: c2, with the write in c1.
  - Error: c1.
- Throughput: at most one transaction in flight. Minimum spacing between accepts is latency + 1 cycles.
- Reset values: state=IDLE, req_ready=0 while rst is high and 1 the cycle after, resp_valid=0, resp_data=0, resp_err=0, mem_we=0, mem_addr=0, mem_wd=0.
- Reset mid-transaction: the transaction is abandoned and no response is produced. No write occurs in any cycle with rst=1, including a reset landing on MERGE or WRITE.
- resp_ready held high in RESP completes the response in that same cycle. resp_ready is ignored outside RESP.

## Structure
- Package lsu_pkg:
  - state enum (IDLE, READ, MERGE, WRITE, RESP).
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - A helper function for the misalignment check.
- Sub-module lsu_lane_align (combinational): extract+extend for loads and merge for stores. Inputs: word, offset, funct3, store data.
- Top: FSM, request/response registers, and the memory-port drive.

## Test plan
- Word store 0xDEADBEEF @0x10 then LW @0x10 -> mem_we pulse with mem_addr=4. LW resp_data=0xDEADBEEF at c3, resp_err=0.
- SB 0xAA @0x13 over 0x11223344 -> c2 write mem_wd=0xAA223344. A following LB @0x13 returns 0xFFFFFFAA; LBU returns 0x000000AA.
- SH 0x8001 @0x12 over 0x11223344 -> mem_wd=0x80013344. LH @0x12 returns 0xFFFF8001; LHU returns 0x00008001.
- LW @0x06 and SH @0x11 -> resp_err=1 at c1, resp_data=0, no mem_we. funct3=011 -> resp_err=1.
- Hold resp_ready=0 for 5 cycles in RESP -> resp_valid and resp_data stable, req_ready=0 throughout.
- rst pulsed during the MERGE cycle of an SB -> mem_we=0 that cycle, memory unchanged. req_ready=1 in the cycle after rst deasserts.
